// File: rtl/comb_unit_arbiter_if.sv
// Requester/unit bundle for comb_unit_arbiter: requests, operands, grant and
// registered responses on one side, the shared combinational unit on the other.
interface comb_unit_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        grant;
   logic [DATA_W-1:0]         unit_in;
   logic                      unit_valid;
   logic [DATA_W-1:0]         unit_out;
   logic [DATA_W-1:0]         rsp_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic                      busy;
   logic                      timeout;

   // Requesters plus the combinational unit.
   modport master (
      output req, req_data, unit_out,
      input  grant, unit_in, unit_valid, rsp_data, rsp_valid, busy, timeout
   );

   // The arbiter.
   modport slave (
      input  req, req_data, unit_out,
      output grant, unit_in, unit_valid, rsp_data, rsp_valid, busy, timeout
   );
endinterface

// File: rtl/comb_unit_arbiter.sv
// Round-robin owner arbiter for one shared combinational unit. Define
// HOLD_TIMEOUT_EN to bound ownership to MAX_HOLD cycles with a timeout pulse.
module comb_unit_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              rst,
   comb_unit_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W:0] NREQ_L = (PTR_W+1)'(NUM_REQ);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t              state_reg;
   logic [NUM_REQ-1:0]  grant_reg;
   logic [NUM_REQ-1:0]  rsp_valid_reg;
   logic [DATA_W-1:0]   rsp_data_reg;
   logic                unit_valid_reg;
   logic                busy_reg;
   logic [PTR_W-1:0]    ptr_reg;
   logic [PTR_W-1:0]    owner_reg;

   logic [NUM_REQ-1:0]  req_rot;
   logic [PTR_W-1:0]    rot_idx;
   logic [PTR_W:0]      rot_sum;
   logic [PTR_W-1:0]    sel_idx;
   logic [PTR_W:0]      ptr_inc;
   logic [PTR_W-1:0]    ptr_next;
   logic                owner_req;
   logic                release_now;
   logic [DATA_W-1:0]   unit_in_mux;
   logic [DATA_W-1:0]   slice_masked [NUM_REQ];

`ifdef HOLD_TIMEOUT_EN
   logic [7:0] hold_cnt_reg;
   logic       timeout_reg;
   logic       force_release;

   assign force_release = owner_req && (hold_cnt_reg == 8'(MAX_HOLD - 1));
`endif

   // Rotate requests so that bit 0 is the requester at the priority pointer.
   assign req_rot = (bus.req >> ptr_reg) | (bus.req << (NREQ_L - {1'b0, ptr_reg}));

   always_comb begin
      rot_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            rot_idx = PTR_W'(i);
         end
      end
      rot_sum = {1'b0, ptr_reg} + {1'b0, rot_idx};
      if (rot_sum >= NREQ_L) begin
         rot_sum = rot_sum - NREQ_L;
      end
      sel_idx = rot_sum[PTR_W-1:0];
   end

   // After a release the previous owner becomes the lowest priority.
   always_comb begin
      ptr_inc  = {1'b0, owner_reg} + 1'b1;
      ptr_next = (ptr_inc == NREQ_L) ? '0 : ptr_inc[PTR_W-1:0];
   end

   assign owner_req = |(bus.req & grant_reg);

`ifdef HOLD_TIMEOUT_EN
   assign release_now = !owner_req || force_release;
`else
   assign release_now = !owner_req;
`endif

   // AND-OR operand mux driven by the registered one-hot grant; zero when idle.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_mux
         assign slice_masked[gi] = bus.req_data[gi*DATA_W +: DATA_W] & {DATA_W{grant_reg[gi]}};
      end
   endgenerate

   always_comb begin
      unit_in_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         unit_in_mux = unit_in_mux | slice_masked[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         rsp_valid_reg  <= '0;
         rsp_data_reg   <= '0;
         unit_valid_reg <= 1'b0;
         busy_reg       <= 1'b0;
         ptr_reg        <= '0;
         owner_reg      <= '0;
`ifdef HOLD_TIMEOUT_EN
         hold_cnt_reg   <= '0;
         timeout_reg    <= 1'b0;
`endif
      end else begin
`ifdef HOLD_TIMEOUT_EN
         timeout_reg <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (|bus.req) begin
                  grant_reg      <= NUM_REQ'(1) << sel_idx;
                  owner_reg      <= sel_idx;
                  unit_valid_reg <= 1'b1;
                  busy_reg       <= 1'b1;
                  state_reg      <= GRANT;
`ifdef HOLD_TIMEOUT_EN
                  hold_cnt_reg   <= '0;
`endif
               end
            end
            GRANT: begin
               // Capture every cycle, including the releasing one, so the
               // final result is delivered one cycle after grant drops.
               rsp_data_reg  <= bus.unit_out;
               rsp_valid_reg <= grant_reg;
               if (release_now) begin
                  grant_reg      <= '0;
                  unit_valid_reg <= 1'b0;
                  ptr_reg        <= ptr_next;
                  state_reg      <= RELEASE;
`ifdef HOLD_TIMEOUT_EN
                  timeout_reg    <= force_release;
`endif
               end else begin
`ifdef HOLD_TIMEOUT_EN
                  hold_cnt_reg   <= hold_cnt_reg + 8'd1;
`endif
               end
            end
            RELEASE: begin
               rsp_valid_reg <= '0;
               busy_reg      <= 1'b0;
               state_reg     <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.grant      = grant_reg;
   assign bus.unit_in    = unit_in_mux;
   assign bus.unit_valid = unit_valid_reg;
   assign bus.rsp_data   = rsp_data_reg;
   assign bus.rsp_valid  = rsp_valid_reg;
   assign bus.busy       = busy_reg;
`ifdef HOLD_TIMEOUT_EN
   assign bus.timeout    = timeout_reg;
`else
   assign bus.timeout    = 1'b0;
`endif

endmodule

// File: doc/comb_unit_arbiter.md
Name: comb_unit_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational compute unit among NUM_REQ requesters.
- Grants exclusive ownership to one requester at a time and steers that requester's operand onto the unit input.
- Registers the unit output back to the owner and reclaims the unit on release, or on timeout when enabled.
- Sits between requester blocks and any generated combinational datapath module.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 32, operand/result width in bits.
- MAX_HOLD, 8, max consecutive grant cycles before forced release (used only with HOLD_TIMEOUT_EN; 1..255).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high for the whole time ownership is wanted.
- req_data  input  NUM_REQ*DATA_W  flattened operands; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  output  NUM_REQ  one-hot ownership, registered.
- unit_in  output  DATA_W  operand driven to the shared combinational unit.
- unit_valid  output  1  high while a grant is active.
- unit_out  input  DATA_W  combinational result from the shared unit.
- rsp_data  output  DATA_W  registered copy of unit_out.
- rsp_valid  output  NUM_REQ  one-hot, marks rsp_data as belonging to requester i.
- busy  output  1  high when state is not IDLE.
- timeout  output  1  1-cycle pulse on forced release (tied 0 without the macro).

Behaviour:
- Reset (async, immediate, including mid-grant): state=IDLE, grant=0, unit_valid=0, unit_in=0, rsp_data=0, rsp_valid=0, busy=0, timeout=0, priority pointer ptr=0, hold counter=0.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0, select the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - The grant bit g is registered on the next edge and the FSM moves to GRANT.
  - Request-to-grant latency is 1 cycle.
  - Requests dropped while in IDLE are not remembered.
- GRANT:
  - grant stays one-hot at g.
  - unit_in = req_data slice g, combinationally muxed from the registered grant.
  - unit_valid=1.
  - Each cycle: rsp_data <= unit_out and rsp_valid <= grant, so the response lags unit_in by 1 cycle.
  - Requests from other requesters are ignored; no preemption.
- Release:
  - When req[g]=0 in GRANT: next edge clears grant and unit_valid, sets ptr=(g+1) mod NUM_REQ, and the FSM goes to RELEASE.
  - rsp_valid stays high for one more cycle, carrying the last result, then clears.
- RELEASE: single dead cycle, grant=0, then IDLE. Minimum spacing between two grants is 2 idle cycles.
- Simultaneous requests: the lowest index at or after ptr wins. After a release, the previous owner has the lowest priority.
- Single requester: it is re-granted repeatedly. ptr wraps from NUM_REQ-1 to 0.
- unit_in = 0 whenever grant = 0.
- grant never has more than one bit set. This is a bench assertion.

Optional Feature:
- Macro: HOLD_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD with req[g] still high, the arbiter forces a release: same transition as a normal release, and timeout pulses high for 1 cycle on the edge that clears grant.
  - The requester may re-compete at lowest priority.
- Undefined: no counter; ownership is unbounded; timeout is tied 0.

Test Plan:
- Single requester: req=4'b0100, req_data[2]=0x0000_00AA, unit_out=unit_in+1 → grant=4'b0100 one cycle later. The cycle after that, rsp_data=0x0000_00AB and rsp_valid=4'b0100. Drop req → grant=0, then busy=0 after RELEASE.
- Simultaneous: req=4'b1011 from reset (ptr=0) → grant order 0, 1, 3. Each requester drops req after 3 cycles. ptr ends at 0 after requester 3 releases.
- Fairness/wrap: requesters 0 and 3 request continuously, releasing after 2 cycles each → grants alternate 0, 3, 0, 3; requester 0 never wins twice in a row.
- Timeout (HOLD_TIMEOUT_EN, MAX_HOLD=8): req[1] held high forever → grant[1] lasts exactly 8 cycles, timeout pulses once, RELEASE, then re-grant to 1. With req[2] also pending, requester 2 is granted first.
- Async reset mid-grant: assert rst while grant=4'b0010, between clock edges → all outputs 0 immediately. After rst deasserts with req=4'b0010 held, grant returns 1 cycle later.
- No-macro build: req[0] held for 50 cycles → grant[0] held for all 50 cycles, timeout stays 0.
